// File: rtl/enc_pkg.sv
// Shared encodings and block-length constants for the ping-pong buffer controller.
package enc_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int SIZE_SMALL = 1056;
    localparam int SIZE_LARGE = 6144;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

endpackage

// File: rtl/pingpong_ctrl_if.sv
// Signals between the block writer, the encoder and pingpong_ctrl.
// The master side is the writer/encoder pair and the slave side is the controller.
interface pingpong_ctrl_if #(
    parameter int ADDR_W = enc_pkg::DEF_ADDR_W
);

    logic              wr_start;
    logic              wr_size_sel;
    logic              wr_valid;
    logic              wr_we;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_busy;
    logic              rd_go;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              rd_size_sel;
    logic [1:0]        full_flags;

    modport master (
        output wr_start, wr_size_sel, wr_valid, rd_go,
        input  wr_we, wr_bank, wr_addr, wr_busy,
        input  rd_en, rd_bank, rd_addr, rd_last, rd_size_sel, full_flags
    );

    modport slave (
        input  wr_start, wr_size_sel, wr_valid, rd_go,
        output wr_we, wr_bank, wr_addr, wr_busy,
        output rd_en, rd_bank, rd_addr, rd_last, rd_size_sel, full_flags
    );

endinterface

// File: rtl/block_counter.sv
// Address counter for one block: clears to zero, advances on enable and
// flags the last address of a small or large block; it never wraps.
module block_counter #(
    parameter int ADDR_W     = enc_pkg::DEF_ADDR_W,
    parameter int SIZE_SMALL = enc_pkg::SIZE_SMALL,
    parameter int SIZE_LARGE = enc_pkg::SIZE_LARGE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              size_sel,
    output logic [ADDR_W-1:0] count,
    output logic              terminal
);

    localparam logic [ADDR_W-1:0] LAST_SMALL = ADDR_W'(SIZE_SMALL - 1);
    localparam logic [ADDR_W-1:0] LAST_LARGE = ADDR_W'(SIZE_LARGE - 1);

    assign terminal = (count == (size_sel ? LAST_LARGE : LAST_SMALL));

    // Holding at the terminal address keeps the counter inside the block.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/pingpong_ctrl.sv
// Two-bank ping-pong buffer controller: one writer fills a bank while the
// encoder drains the other, each bank cycling EMPTY->FILLING->FULL->DRAINING.
module pingpong_ctrl
    import enc_pkg::*;
#(
    parameter int ADDR_W     = enc_pkg::DEF_ADDR_W,
    parameter int SIZE_SMALL = enc_pkg::SIZE_SMALL,
    parameter int SIZE_LARGE = enc_pkg::SIZE_LARGE
) (
    input  logic           clock,
    input  logic           reset,
    pingpong_ctrl_if.slave bus
);

    wr_state_t         wr_state;
    rd_state_t         rd_state;
    bank_state_t       bank_state [2];
    logic [1:0]        bank_size;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_term;
    logic              rd_term;
    logic              wr_busy;
    logic              wr_accept;
    logic              wr_we;
    logic              rd_accept;
    logic              rd_en;
    logic              rd_last;

    // Busy only looks at registered state, so a bank freed on this edge opens next cycle.
    assign wr_busy   = (wr_state == W_FILL) || (bank_state[wr_bank] != BANK_EMPTY);
    assign wr_accept = bus.wr_start && !wr_busy;
    assign wr_we     = bus.wr_valid && (wr_state == W_FILL);
    assign rd_accept = (rd_state == R_IDLE) && bus.rd_go && (bank_state[rd_bank] == BANK_FULL);
    assign rd_en     = (rd_state == R_DRAIN);
    assign rd_last   = rd_en && rd_term;

    block_counter #(
        .ADDR_W     (ADDR_W),
        .SIZE_SMALL (SIZE_SMALL),
        .SIZE_LARGE (SIZE_LARGE)
    ) u_wr_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear    (wr_accept),
        .enable   (wr_we),
        .size_sel (bank_size[wr_bank]),
        .count    (wr_addr),
        .terminal (wr_term)
    );

    block_counter #(
        .ADDR_W     (ADDR_W),
        .SIZE_SMALL (SIZE_SMALL),
        .SIZE_LARGE (SIZE_LARGE)
    ) u_rd_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear    (rd_accept),
        .enable   (rd_en),
        .size_sel (bank_size[rd_bank]),
        .count    (rd_addr),
        .terminal (rd_term)
    );

    // The two FSMs only ever touch different banks, so sharing one block is safe.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state      <= W_IDLE;
            rd_state      <= R_IDLE;
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            bank_size     <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (wr_accept) begin
                        bank_state[wr_bank] <= BANK_FILLING;
                        bank_size[wr_bank]  <= bus.wr_size_sel;
                        wr_state            <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (wr_we && wr_term) begin
                        bank_state[wr_bank] <= BANK_FULL;
                        wr_bank             <= ~wr_bank;
                        wr_state            <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase

            case (rd_state)
                R_IDLE: begin
                    if (rd_accept) begin
                        bank_state[rd_bank] <= BANK_DRAINING;
                        rd_state            <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    if (rd_last) begin
                        bank_state[rd_bank] <= BANK_EMPTY;
                        rd_bank             <= ~rd_bank;
                        rd_state            <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign bus.wr_we       = wr_we;
    assign bus.wr_bank     = wr_bank;
    assign bus.wr_addr     = wr_addr;
    assign bus.wr_busy     = wr_busy;
    assign bus.rd_en       = rd_en;
    assign bus.rd_bank     = rd_bank;
    assign bus.rd_addr     = rd_addr;
    assign bus.rd_last     = rd_last;
    assign bus.rd_size_sel = bank_size[rd_bank];
    assign bus.full_flags  = {bank_state[1] == BANK_FULL, bank_state[0] == BANK_FULL};

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Randomized scoreboard bench for pingpong_ctrl: a per-bank block model predicts
// every buffer write and read, and a negedge monitor checks them as they appear.
module tb_pingpong_ctrl;

    localparam int ADDR_W    = 13;
    localparam int LEN_SMALL = 1056;
    localparam int LEN_LARGE = 6144;
    localparam int VALID_PCT = 85;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    pingpong_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    pingpong_ctrl #(
        .ADDR_W     (ADDR_W),
        .SIZE_SMALL (LEN_SMALL),
        .SIZE_LARGE (LEN_LARGE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [ADDR_W:0]   wr_exp [$];
    logic [ADDR_W+2:0] rd_exp [$];
    bit                m_full [2];
    bit                m_size [2];
    bit                m_wr_bank;
    bit                m_rd_bank;
    int                last_len;

    function automatic int blk_len(input bit sz);
        return sz ? LEN_LARGE : LEN_SMALL;
    endfunction

    function automatic logic [1:0] exp_flags();
        return {m_full[1], m_full[0]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every buffer access the DUT presents must match the next predicted one.
    always @(negedge clock) begin
        if (bus.wr_we === 1'b1) begin
            if (wr_exp.size() == 0) begin
                check_output("wr_we_unexpected", 32'(bus.wr_we), 32'd0);
            end else begin
                check_output("wr_bank_addr", 32'({bus.wr_bank, bus.wr_addr}), 32'(wr_exp.pop_front()));
            end
        end
        if (bus.rd_en === 1'b1) begin
            if (rd_exp.size() == 0) begin
                check_output("rd_en_unexpected", 32'(bus.rd_en), 32'd0);
            end else begin
                check_output("rd_size_last_bank_addr",
                             32'({bus.rd_size_sel, bus.rd_last, bus.rd_bank, bus.rd_addr}),
                             32'(rd_exp.pop_front()));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_wr_we"},       32'(bus.wr_we),       32'd0);
        check_output({tag, "_rd_en"},       32'(bus.rd_en),       32'd0);
        check_output({tag, "_rd_last"},     32'(bus.rd_last),     32'd0);
        check_output({tag, "_full_flags"},  32'(bus.full_flags),  32'd0);
        check_output({tag, "_wr_busy"},     32'(bus.wr_busy),     32'd0);
        check_output({tag, "_wr_addr"},     32'(bus.wr_addr),     32'd0);
        check_output({tag, "_rd_addr"},     32'(bus.rd_addr),     32'd0);
        check_output({tag, "_wr_bank"},     32'(bus.wr_bank),     32'd0);
        check_output({tag, "_rd_bank"},     32'(bus.rd_bank),     32'd0);
        check_output({tag, "_rd_size_sel"}, 32'(bus.rd_size_sel), 32'd0);
    endtask

    task automatic do_fill(input bit sz);
        int n = blk_len(sz);
        bit b = m_wr_bank;
        int i = 0;
        bus.wr_start    = 1'b1;
        bus.wr_size_sel = sz;
        bus.wr_valid    = ($urandom_range(1) == 1);
        tick();
        bus.wr_start    = 1'b0;
        bus.wr_size_sel = 1'($urandom_range(1));
        check_output("fill_busy", 32'(bus.wr_busy), 32'd1);
        m_size[b] = sz;
        while (i < n) begin
            if ($urandom_range(99) < VALID_PCT) begin
                bus.wr_valid = 1'b1;
                wr_exp.push_back({b, ADDR_W'(i)});
                i++;
            end else begin
                bus.wr_valid = 1'b0;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        m_full[b] = 1'b1;
        m_wr_bank = ~b;
        last_len  = n;
        check_output("fill_wr_bank", 32'(bus.wr_bank), 32'(m_wr_bank));
        check_output("fill_wr_addr", 32'(bus.wr_addr), 32'(n - 1));
        check_output("fill_queue_empty", 32'(wr_exp.size()), 32'd0);
    endtask

    task automatic push_drain(input bit b);
        int n = blk_len(m_size[b]);
        for (int i = 0; i < n; i++) begin
            rd_exp.push_back({m_size[b], (i == n - 1), b, ADDR_W'(i)});
        end
    endtask

    task automatic do_drain();
        bit b = m_rd_bank;
        int n = blk_len(m_size[b]);
        int c = 0;
        push_drain(b);
        bus.rd_go = 1'b1;
        tick();
        bus.rd_go = 1'b0;
        while (c < n + 20 && rd_exp.size() != 0) begin
            tick();
            c++;
        end
        check_output("drain_done", 32'(rd_exp.size()), 32'd0);
        check_output("drain_cycles", 32'(c), 32'(n));
        m_full[b] = 1'b0;
        m_rd_bank = ~b;
        check_output("drain_rd_bank", 32'(bus.rd_bank), 32'(m_rd_bank));
        check_output("drain_rd_en_off", 32'(bus.rd_en), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit b;
        int n;
        int c;
        bus.wr_start    = 1'b0;
        bus.wr_size_sel = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.rd_go       = 1'b0;
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_size[0] = 1'b0; m_size[1] = 1'b0;
        m_wr_bank = 1'b0;
        m_rd_bank = 1'b0;
        last_len  = 0;

        reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Single small block in, then out.
        do_fill(1'b0);
        check_output("fill0_flags", 32'(bus.full_flags), 32'(exp_flags()));
        do_drain();
        check_output("drain0_flags", 32'(bus.full_flags), 32'(exp_flags()));

        // Random-size fill, then two overlapped fill/drain rounds on opposite banks.
        do_fill(1'($urandom_range(1)));
        check_output("fill1_flags", 32'(bus.full_flags), 32'(exp_flags()));
        fork
            do_drain();
            do_fill(1'b0);
        join
        check_output("overlap1_flags", 32'(bus.full_flags), 32'(exp_flags()));
        fork
            do_drain();
            do_fill(1'b1);
        join
        check_output("overlap2_flags", 32'(bus.full_flags), 32'(exp_flags()));
        check_output("overlap2_wr_bank", 32'(bus.wr_bank), 32'(m_wr_bank));
        check_output("overlap2_rd_bank", 32'(bus.rd_bank), 32'(m_rd_bank));

        // Both banks full: a new block must be refused.
        do_fill(1'($urandom_range(1)));
        check_output("both_full_flags", 32'(bus.full_flags), 32'(exp_flags()));
        check_output("busy_before", 32'(bus.wr_busy), 32'(m_full[m_wr_bank]));
        bus.wr_start    = 1'b1;
        bus.wr_size_sel = 1'b1;
        bus.wr_valid    = 1'b1;
        tick();
        bus.wr_start = 1'b0;
        repeat (4) tick();
        bus.wr_valid = 1'b0;
        check_output("busy_after", 32'(bus.wr_busy), 32'd1);
        check_output("busy_flags", 32'(bus.full_flags), 32'(exp_flags()));
        check_output("busy_wr_addr", 32'(bus.wr_addr), 32'(last_len - 1));

        // wr_start in the rd_last cycle of the target bank is refused, one cycle later it is taken.
        b = m_rd_bank;
        n = blk_len(m_size[b]);
        check_output("coinc_target", 32'(bus.wr_bank), 32'(b));
        push_drain(b);
        bus.rd_go = 1'b1;
        tick();
        bus.rd_go = 1'b0;
        c = 0;
        while (bus.rd_last !== 1'b1 && c < n + 20) begin
            tick();
            c++;
        end
        check_output("coinc_rd_last_seen", 32'(bus.rd_last), 32'd1);
        bus.wr_start    = 1'b1;
        bus.wr_size_sel = 1'b0;
        check_output("coinc_busy", 32'(bus.wr_busy), 32'd1);
        tick();
        bus.wr_start = 1'b0;
        m_full[b] = 1'b0;
        m_rd_bank = ~b;
        check_output("coinc_freed_busy", 32'(bus.wr_busy), 32'd0);
        check_output("coinc_rd_done", 32'(rd_exp.size()), 32'd0);
        do_fill(1'b0);
        check_output("coinc_fill_flags", 32'(bus.full_flags), 32'(exp_flags()));

        // Reset in the middle of a drain discards everything.
        b = m_rd_bank;
        push_drain(b);
        bus.rd_go = 1'b1;
        tick();
        bus.rd_go = 1'b0;
        m_full[b] = 1'b0;
        c = 0;
        while (bus.rd_addr != ADDR_W'(500) && c < 600) begin
            tick();
            c++;
        end
        check_output("mid_drain_addr", 32'(bus.rd_addr), 32'd500);
        check_output("mid_drain_flags", 32'(bus.full_flags), 32'(exp_flags()));
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        rd_exp.delete();
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_wr_bank = 1'b0;
        m_rd_bank = 1'b0;
        tick();
        check_output("post_reset_flags", 32'(bus.full_flags), 32'(exp_flags()));
        check_output("final_wr_queue", 32'(wr_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13, sets the buffer address width.
REQ-002 Parameter SIZE_SMALL, default 1056, is the small block length in bits.
REQ-003 Parameter SIZE_LARGE, default 6144, is the large block length in bits.
REQ-004 clock  in  1  system clock; all logic is on its rising edge.
REQ-005 reset  in  1  reset, synchronous and active-high.
REQ-006 wr_start  in  1  one-cycle pulse that opens a new input block.
REQ-007 wr_size_sel  in  1  block size, sampled with wr_start: 0 selects SIZE_SMALL, 1 selects SIZE_LARGE.
REQ-008 wr_valid  in  1  one input bit is present this cycle.
REQ-009 wr_we  out  1  buffer write enable.
REQ-010 wr_bank  out  1  bank being written.
REQ-011 wr_addr  out  ADDR_W  write address.
REQ-012 wr_busy  out  1  high when a wr_start would be rejected.
REQ-013 rd_go  in  1  encoder ready to consume a block.
REQ-014 rd_en  out  1  buffer read enable.
REQ-015 rd_bank  out  1  bank being read.
REQ-016 rd_addr  out  ADDR_W  read address.
REQ-017 rd_last  out  1  marks the final read of a block.
REQ-018 rd_size_sel  out  1  size of the block being read.
REQ-019 full_flags  out  2  bit i is high while bank i is FULL.

Function
REQ-020 Each bank SHALL have a state EMPTY, FILLING, FULL or DRAINING, plus a latched size bit.
REQ-021 Write FSM SHALL have states W_IDLE and W_FILL.
- W_IDLE -> W_FILL on wr_start when bank[wr_bank] is EMPTY.
- That bank becomes FILLING and latches wr_size_sel.
- wr_addr is cleared to 0.
REQ-022 wr_busy SHALL equal (W_FILL) or (bank[wr_bank] not EMPTY), from registered state only.
REQ-023 A wr_start seen while wr_busy is high SHALL be ignored with no state change.
REQ-024 wr_we SHALL be wr_valid AND W_FILL, combinational in the same cycle; wr_valid in the wr_start cycle is ignored.
REQ-025 wr_addr SHALL increment by 1 on each wr_we.
REQ-026 When wr_we occurs at wr_addr = size-1, the write FSM SHALL, on that edge:
- set the bank to FULL;
- toggle the wr_bank pointer;
- return to W_IDLE.
REQ-027 Read FSM SHALL have states R_IDLE and R_DRAIN.
- R_IDLE -> R_DRAIN when rd_go=1 and bank[rd_bank] is FULL.
- That bank becomes DRAINING and rd_addr is cleared to 0.
REQ-028 In R_DRAIN, rd_en SHALL be 1 every cycle (no backpressure) and rd_addr SHALL increment per cycle.
REQ-029 rd_last SHALL be 1 only when rd_addr = size-1 in R_DRAIN.
- On that edge the bank becomes EMPTY, rd_bank toggles and the FSM returns to R_IDLE.
- rd_en is 0 in the following cycle.
REQ-030 The first rd_en SHALL occur one cycle after the rd_go acceptance cycle.
REQ-031 rd_size_sel SHALL reflect the latched size of rd_bank.
REQ-032 A bank freed at an edge SHALL be writable from the next cycle.
- A wr_start coincident with that bank's rd_last is rejected (wr_busy=1).
REQ-033 Write and read SHALL proceed concurrently on opposite banks; both FSMs never target the same bank in a non-FULL/EMPTY state.
REQ-034 Address counters SHALL never exceed size-1; there is no modular wrap inside a block.

Reset
REQ-035 On reset the following SHALL hold:
- both FSMs idle;
- both banks EMPTY with size bits 0;
- wr_bank=0, rd_bank=0, wr_addr=0, rd_addr=0;
- wr_we=0, rd_en=0, rd_last=0, full_flags=0, wr_busy=0.
REQ-036 Reset asserted mid-fill or mid-drain SHALL discard all blocks, with outputs at reset values on the next cycle.

Structure
REQ-037 Package enc_pkg SHALL hold the bank state encoding, the FSM state encodings and the SIZE_SMALL/SIZE_LARGE constants.
REQ-038 One sub-module, block_counter (ADDR_W counter with clear, enable and terminal-count compare against a size select), SHALL be instantiated twice.

Verification
REQ-039 Fill: reset, wr_start with size 0, then 1056 wr_valid -> wr_addr 0..1055, full_flags=01 and wr_bank=1 after the last write.
REQ-040 Drain: after REQ-039, rd_go -> 1056 consecutive rd_en on bank 0, rd_last at rd_addr 1055, full_flags=00.
REQ-041 Overlap: fill bank 1 (size 1, 6144 bits) while bank 0 drains -> both complete with independent addresses.
REQ-042 Busy: both banks FULL, then wr_start -> ignored, wr_busy=1, no wr_we.
REQ-043 Coincidence: wr_start in the cycle of rd_last on the target bank -> rejected; the same wr_start one cycle later -> accepted.
REQ-044 Reset mid-drain at rd_addr 500 -> all outputs at reset values next cycle, full_flags=00.
